// File: rtl/wb_port_arbiter.sv
// Two-requester register-file writeback arbiter.
// Requester A (pipeline writeback) has fixed priority. Requester B (a multi-cycle
// unit) is forced through after STARVE_LIMIT consecutive blocked cycles. The
// granted write is registered one cycle later. Writes to index 15 are accepted
// but never enabled, and they are counted in a saturating drop counter.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [3:0]  a_dest,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [3:0]  b_dest,
    input  logic [31:0] b_data,
    output logic        b_ready,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_wb,
    output logic [7:0]  drop_count
);

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_B = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);
    localparam logic [3:0] NULL_DEST   = 4'hF;

    state_t      state;
    state_t      state_next;
    logic [3:0]  starve_cnt;
    logic [3:0]  starve_next;

    logic        a_xfer;
    logic        b_xfer;
    logic        xfer;
    logic [3:0]  grant_dest;
    logic [31:0] grant_data;

    // State register and starve counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
        end
    end

    // Next-state logic: count cycles in which B is blocked by A.
    always_comb begin
        state_next  = state;
        starve_next = '0;
        case (state)
            NORMAL: begin
                if (a_valid && b_valid) begin
                    if (starve_cnt == STARVE_LAST) begin
                        state_next  = FORCE_B;
                        starve_next = '0;
                    end else begin
                        starve_next = starve_cnt + 4'd1;
                    end
                end
            end
            FORCE_B: begin
                state_next  = NORMAL;
                starve_next = '0;
            end
            default: begin
                state_next  = NORMAL;
                starve_next = '0;
            end
        endcase
    end

    // Ready outputs: depend on state and a_valid only; both held low in reset.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (!rst) begin
            case (state)
                NORMAL: begin
                    a_ready = 1'b1;
                    b_ready = !a_valid;
                end
                FORCE_B: begin
                    a_ready = 1'b0;
                    b_ready = 1'b1;
                end
                default: begin
                    a_ready = 1'b0;
                    b_ready = 1'b0;
                end
            endcase
        end
    end

    // Grant mux: at most one of a_xfer / b_xfer can be set in a cycle.
    always_comb begin
        a_xfer     = a_valid && a_ready;
        b_xfer     = b_valid && b_ready && !a_xfer;
        xfer       = a_xfer || b_xfer;
        grant_dest = a_xfer ? a_dest : b_dest;
        grant_data = a_xfer ? a_data : b_data;
    end

    // Registered writeback port and drop counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            writeBackEn <= 1'b0;
            Dest_wb     <= '0;
            Result_wb   <= '0;
            drop_count  <= '0;
        end else begin
            writeBackEn <= xfer && (grant_dest != NULL_DEST);
            if (xfer) begin
                Dest_wb   <= grant_dest;
                Result_wb <= grant_data;
                if ((grant_dest == NULL_DEST) && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table plus hand-written sequences
// for drop-counter saturation and reset while B is being forced. A second
// instance with STARVE_LIMIT=1 shares the inputs to observe A/B alternation.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst;
    logic        a_valid;
    logic [3:0]  a_dest;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_dest;
    logic [31:0] b_data;
    logic        b_ready;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic [7:0]  drop_count;

    logic        alt_a_ready;
    logic        alt_b_ready;
    logic        alt_wben;
    logic [3:0]  alt_dest;
    logic [31:0] alt_result;
    logic [7:0]  alt_drop;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(.STARVE_LIMIT(3)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(b_ready),
        .writeBackEn(writeBackEn), .Dest_wb(Dest_wb), .Result_wb(Result_wb),
        .drop_count(drop_count)
    );

    wb_port_arbiter #(.STARVE_LIMIT(1)) u_alt (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data), .a_ready(alt_a_ready),
        .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data), .b_ready(alt_b_ready),
        .writeBackEn(alt_wben), .Dest_wb(alt_dest), .Result_wb(alt_result),
        .drop_count(alt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Protocol monitor: no double ready with a_valid, and exactly one cycle
    // from transfer to writeBackEn.
    logic exp_wb_pending = 1'b0;
    logic mon_armed      = 1'b0;

    always @(posedge clk) begin
        if (a_valid && a_ready && b_ready) begin
            checks++;
            errors++;
            $display("FAIL proto_both_ready: got a_ready=1 b_ready=1 expected not both with a_valid=1 at %0t", $time);
        end
        if (a_valid && a_ready)
            exp_wb_pending <= (a_dest != 4'hF);
        else if (b_valid && b_ready)
            exp_wb_pending <= (b_dest != 4'hF);
        else
            exp_wb_pending <= 1'b0;
        mon_armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (mon_armed && !rst) begin
            checks++;
            if (writeBackEn !== exp_wb_pending) begin
                errors++;
                $display("FAIL proto_latency: got writeBackEn=%0b expected %0b at %0t",
                         writeBackEn, exp_wb_pending, $time);
            end
        end
    end

    typedef struct {
        logic        av;
        logic [3:0]  ad;
        logic [31:0] adata;
        logic        bv;
        logic [3:0]  bd;
        logic [31:0] bdata;
        logic        ar;
        logic        br;
        logic        wb;
        logic [3:0]  dest;
        logic [31:0] res;
        logic [7:0]  drop;
        logic        alt_ar;
    } vec_t;

    vec_t vecs[17];

    initial begin
        //          av ad     adata          bv bd     bdata   ar br wb dest   res            drop  alt_ar
        vecs[0]  = '{0, 4'h0, 32'h0,         0, 4'h0, 32'h0,  1, 1, 0, 4'h0, 32'h0,         8'd0, 1};
        vecs[1]  = '{1, 4'h3, 32'hDEADBEEF,  0, 4'h0, 32'h0,  1, 0, 1, 4'h3, 32'hDEADBEEF,  8'd0, 1};
        vecs[2]  = '{0, 4'h3, 32'hDEADBEEF,  0, 4'h0, 32'h0,  1, 1, 0, 4'h3, 32'hDEADBEEF,  8'd0, 1};
        vecs[3]  = '{0, 4'h0, 32'h0,         1, 4'h2, 32'h22, 1, 1, 1, 4'h2, 32'h22,        8'd0, 1};
        vecs[4]  = '{1, 4'hF, 32'h55,        0, 4'h0, 32'h0,  1, 0, 0, 4'hF, 32'h55,        8'd1, 1};
        vecs[5]  = '{0, 4'h0, 32'h0,         1, 4'hF, 32'h66, 1, 1, 0, 4'hF, 32'h66,        8'd2, 1};
        vecs[6]  = '{1, 4'h1, 32'h11,        1, 4'h5, 32'h7,  1, 0, 1, 4'h1, 32'h11,        8'd2, 1};
        vecs[7]  = '{1, 4'h1, 32'h11,        1, 4'h5, 32'h7,  1, 0, 1, 4'h1, 32'h11,        8'd2, 0};
        vecs[8]  = '{1, 4'h1, 32'h11,        1, 4'h5, 32'h7,  1, 0, 1, 4'h1, 32'h11,        8'd2, 1};
        vecs[9]  = '{1, 4'h1, 32'h11,        1, 4'h5, 32'h7,  0, 1, 1, 4'h5, 32'h7,         8'd2, 0};
        vecs[10] = '{1, 4'h1, 32'h11,        1, 4'h5, 32'h7,  1, 0, 1, 4'h1, 32'h11,        8'd2, 1};
        vecs[11] = '{1, 4'h4, 32'h44,        0, 4'h5, 32'h7,  1, 0, 1, 4'h4, 32'h44,        8'd2, 0};
        vecs[12] = '{1, 4'h4, 32'h44,        1, 4'h5, 32'h7,  1, 0, 1, 4'h4, 32'h44,        8'd2, 1};
        vecs[13] = '{1, 4'h4, 32'h44,        1, 4'h5, 32'h7,  1, 0, 1, 4'h4, 32'h44,        8'd2, 0};
        vecs[14] = '{1, 4'h4, 32'h44,        1, 4'h5, 32'h7,  1, 0, 1, 4'h4, 32'h44,        8'd2, 1};
        vecs[15] = '{1, 4'h4, 32'h44,        1, 4'h5, 32'h7,  0, 1, 1, 4'h5, 32'h7,         8'd2, 0};
        vecs[16] = '{0, 4'h0, 32'h0,         0, 4'h0, 32'h0,  1, 1, 0, 4'h5, 32'h7,         8'd2, 1};

        rst     = 1'b1;
        a_valid = 1'b0;
        a_dest  = '0;
        a_data  = '0;
        b_valid = 1'b0;
        b_dest  = '0;
        b_data  = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 32'(a_ready), 32'h0);
        chk("rst_b_ready", 32'(b_ready), 32'h0);
        chk("rst_wben", 32'(writeBackEn), 32'h0);
        chk("rst_dest", 32'(Dest_wb), 32'h0);
        chk("rst_result", Result_wb, 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        rst = 1'b0;

        // Table: inputs at negedge, readies checked mid-cycle, registers after the edge
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_valid = vecs[i].av;
            a_dest  = vecs[i].ad;
            a_data  = vecs[i].adata;
            b_valid = vecs[i].bv;
            b_dest  = vecs[i].bd;
            b_data  = vecs[i].bdata;
            #1;
            chk($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
            chk($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].br));
            chk($sformatf("v%0d_alt_a_ready", i), 32'(alt_a_ready), 32'(vecs[i].alt_ar));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wben", i), 32'(writeBackEn), 32'(vecs[i].wb));
            chk($sformatf("v%0d_dest", i), 32'(Dest_wb), 32'(vecs[i].dest));
            chk($sformatf("v%0d_result", i), Result_wb, vecs[i].res);
            chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vecs[i].drop));
        end

        // Index 15 held for 300 cycles: always accepted, never written, counter saturates
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_dest  = 4'hF;
            a_data  = 32'(i);
            b_valid = 1'b0;
            #1;
            chk("sat_a_ready", 32'(a_ready), 32'h1);
            @(posedge clk);
            #1;
            chk("sat_wben", 32'(writeBackEn), 32'h0);
        end
        chk("sat_drop", 32'(drop_count), 32'hFF);

        // Reset while in FORCE_B
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_valid = 1'b1;
            a_dest  = 4'h1;
            a_data  = 32'h11;
            b_valid = 1'b1;
            b_dest  = 4'h5;
            b_data  = 32'h7;
            #1;
            chk("rf_pre_a_ready", 32'(a_ready), 32'h1);
        end
        @(negedge clk);
        #1;
        chk("rf_force_a_ready", 32'(a_ready), 32'h0);
        chk("rf_force_b_ready", 32'(b_ready), 32'h1);
        rst = 1'b1;
        #1;
        chk("rf_rst_a_ready", 32'(a_ready), 32'h0);
        chk("rf_rst_b_ready", 32'(b_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rf_post_a_ready", 32'(a_ready), 32'h1);
        chk("rf_post_b_ready", 32'(b_ready), 32'h0);
        chk("rf_post_wben", 32'(writeBackEn), 32'h0);
        chk("rf_post_dest", 32'(Dest_wb), 32'h0);
        chk("rf_post_drop", 32'(drop_count), 32'h0);
        // Counter restarted from 0: three A grants, then B
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rf_after_wben", 32'(writeBackEn), 32'h1);
            chk("rf_after_dest", 32'(Dest_wb), 32'h1);
            @(negedge clk);
            #1;
            if (i < 2) chk("rf_after_a_ready", 32'(a_ready), 32'h1);
        end
        chk("rf_force_again_b_ready", 32'(b_ready), 32'h1);
        chk("rf_force_again_a_ready", 32'(a_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("rf_b_dest", 32'(Dest_wb), 32'h5);
        chk("rf_b_result", Result_wb, 32'h7);
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
